// File: rtl/spi_lcd_slave.sv
// rtl/spi_lcd_slave.sv - SPI mode-0 target for the 9-bit LCD link
// Oversampled receive into a FWFT FIFO, preloaded response word shifted out on miso.
module spi_lcd_slave #(
  parameter int FRAME_BITS  = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          Bus2IP_Clk,
  input  logic                          Bus2IP_Resetn,
  input  logic                          csn,
  input  logic                          sck,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [FRAME_BITS-1:0]         tx_data,
  input  logic                          tx_we,
  output logic [FRAME_BITS-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
  logic                   csn_r, csn_prev, sck_r, sck_prev, mosi_r;
  logic [BW-1:0]          bit_cnt;
  logic [FRAME_BITS-2:0]  rx_shift;
  logic [FRAME_BITS-1:0]  tx_hold, tx_shift;
  logic [FRAME_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic selected, rise, fall, csn_fall, csn_rise;
  logic push, pop, full, wr_en;
  logic [FRAME_BITS-1:0] word;

  assign selected = ~csn_r;
  assign rise     = sck_r & ~sck_prev;
  assign fall     = ~sck_r & sck_prev;
  assign csn_fall = ~csn_r & csn_prev;
  assign csn_rise = csn_r & ~csn_prev;
  assign word     = {rx_shift, mosi_r};

  assign push  = rise & selected & (bit_cnt == LAST_BIT);
  assign pop   = rx_valid & rx_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  assign rx_valid = (count != '0);
  assign rx_count = count;
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
  assign miso_oe  = selected;
  assign miso     = selected & tx_shift[FRAME_BITS-1];

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      csn_sync  <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      csn_r     <= 1'b1;
      csn_prev  <= 1'b1;
      sck_r     <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_r    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_r     <= csn_sync[SYNC_STAGES-1];
      csn_prev  <= csn_r;
      sck_r     <= sck_sync[SYNC_STAGES-1];
      sck_prev  <= sck_r;
      mosi_r    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rise && selected) begin
        rx_shift <= word[FRAME_BITS-2:0];
        bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end else if (csn_rise && bit_cnt != '0) begin
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

  // Reload on the first fall after a word completes so the next MSB is ready before its rise.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      tx_hold  <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_we) tx_hold <= tx_data;
      if (csn_fall) tx_shift <= tx_hold;
      else if (fall && selected) begin
        if (bit_cnt == '0) tx_shift <= tx_hold;
        else               tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_slave.sv
// tb/tb_spi_lcd_slave.sv - directed bench for spi_lcd_slave
// Drives mode-0 frames at sck = clk/8 and checks FIFO, miso, abort and reset behaviour.
module tb_spi_lcd_slave;

  logic       tb_Bus2IP_Clk = 1'b0;
  logic       rst_n;
  logic       csn, sck, mosi, miso, miso_oe;
  logic [8:0] tx_data, rx_data;
  logic       tx_we, rx_valid, rx_ready, overflow, overflow_clr, frame_err;
  logic [2:0] rx_count;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int vcyc = 0;
  logic [8:0] got[$];
  logic [8:0] mo_word, mo_word2;

  always #5 tb_Bus2IP_Clk = ~tb_Bus2IP_Clk;

  spi_lcd_slave dut (
    .Bus2IP_Clk    (tb_Bus2IP_Clk),
    .Bus2IP_Resetn (rst_n),
    .csn           (csn),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
    .miso_oe       (miso_oe),
    .tx_data       (tx_data),
    .tx_we         (tx_we),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_count      (rx_count),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .frame_err     (frame_err)
  );

  always @(negedge tb_Bus2IP_Clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) vcyc++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge tb_Bus2IP_Clk);
  endtask

  task automatic bit_xfer(input logic b, output logic mo);
    mosi = b;
    sck  = 1'b0;
    wait_n(4);
    mo  = miso;
    sck = 1'b1;
    wait_n(4);
  endtask

  // mode 1: check rx_valid latency after the last rise; mode 2: pop exactly in the push cycle
  task automatic word_xfer(input logic [8:0] w, input int mode, output logic [8:0] mo_w);
    logic mo;
    for (int i = 8; i >= 0; i--) begin
      if (i == 0 && mode != 0) begin
        mosi = w[0];
        sck  = 1'b0;
        wait_n(4);
        mo_w[0] = miso;
        sck = 1'b1;
        wait_n(3);
        if (mode == 1) check("lat_before", rx_valid, 1'b0);
        if (mode == 2) rx_ready = 1'b1;
        wait_n(1);
        if (mode == 1) check("lat_at", rx_valid, 1'b1);
        if (mode == 2) rx_ready = 1'b0;
        wait_n(3);
      end else begin
        bit_xfer(w[i], mo);
        mo_w[i] = mo;
      end
    end
    sck = 1'b0;
    wait_n(4);
  endtask

  task automatic send_frame(input logic [8:0] w, input int mode);
    csn = 1'b0;
    wait_n(8);
    word_xfer(w, mode, mo_word);
    csn = 1'b1;
    wait_n(8);
  endtask

  initial begin
    logic mo;
    int f0;
    rst_n = 1'b0; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = '0; tx_we = 1'b0; rx_ready = 1'b0; overflow_clr = 1'b0;
    wait_n(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_count", rx_count, 3'd0);
    check("rst_oe", miso_oe, 1'b0);
    rst_n = 1'b1;
    wait_n(3);

    // two frames with rx_ready held high
    rx_ready = 1'b1; got.delete(); vcyc = 0;
    send_frame(9'h1FF, 0);
    send_frame(9'h15A, 0);
    check("t1_n", got.size(), 2);
    check("t1_w0", got[0], 9'h1FF);
    check("t1_w1", got[1], 9'h15A);
    check("t1_vcyc", vcyc, 2);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovf", overflow, 1'b0);

    // response word 0x0A5 on miso
    tx_data = 9'h0A5; tx_we = 1'b1; wait_n(1); tx_we = 1'b0; tx_data = 9'h000;
    got.delete();
    send_frame(9'h100, 1);
    check("t2_miso", mo_word, 9'h0A5);
    check("t2_rx", got[0], 9'h100);
    check("t2_oe_idle", miso_oe, 1'b0);

    // overflow: five frames into a four-deep FIFO
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(9'(i), 0);
    check("t3_count", rx_count, 3'd4);
    check("t3_ovf", overflow, 1'b1);
    check("t3_head", rx_data, 9'h001);
    got.delete(); rx_ready = 1'b1; wait_n(10); rx_ready = 1'b0;
    check("t3_n", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_pop", got[i], 9'(i + 1));
    check("t3_ovf_sticky", overflow, 1'b1);
    overflow_clr = 1'b1; wait_n(1); overflow_clr = 1'b0; wait_n(1);
    check("t3_ovf_clr", overflow, 1'b0);

    // abort after four bits
    f0 = ferr_cnt;
    csn = 1'b0; wait_n(8);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, mo);
    sck = 1'b0; wait_n(4); csn = 1'b1; wait_n(8);
    check("t4_ferr", ferr_cnt - f0, 1);
    check("t4_count", rx_count, 3'd0);
    rx_ready = 1'b1; got.delete();
    send_frame(9'h0C3, 0);
    check("t4_rx", got[0], 9'h0C3);
    check("t4_n", got.size(), 1);

    // 18 bits in one csn-low period
    got.delete(); f0 = ferr_cnt;
    csn = 1'b0; wait_n(8);
    word_xfer(9'h1FF, 0, mo_word);
    word_xfer(9'h02A, 0, mo_word2);
    csn = 1'b1; wait_n(8);
    check("t5_n", got.size(), 2);
    check("t5_w0", got[0], 9'h1FF);
    check("t5_w1", got[1], 9'h02A);
    check("t5_miso0", mo_word, 9'h0A5);
    check("t5_miso1", mo_word2, 9'h0A5);
    check("t5_ferr", ferr_cnt - f0, 0);

    // full FIFO with push and pop in the same cycle
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(9'h010 + 9'(i), 0);
    check("t6_full", rx_count, 3'd4);
    got.delete();
    send_frame(9'h014, 2);
    check("t6_count", rx_count, 3'd4);
    check("t6_ovf", overflow, 1'b0);
    check("t6_popped", got[0], 9'h010);
    got.delete(); rx_ready = 1'b1; wait_n(10); rx_ready = 1'b0;
    check("t6_n", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t6_pop", got[i], 9'h011 + 9'(i));

    // reset mid-frame
    send_frame(9'h0FE, 0);
    csn = 1'b0; wait_n(8);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, mo);
    check("t7_oe_sel", miso_oe, 1'b1);
    check("t7_count_pre", rx_count, 3'd1);
    rst_n = 1'b0; wait_n(1);
    check("t7_count", rx_count, 3'd0);
    check("t7_valid", rx_valid, 1'b0);
    check("t7_data", rx_data, 9'h000);
    check("t7_oe", miso_oe, 1'b0);
    check("t7_miso", miso, 1'b0);
    check("t7_ovf", overflow, 1'b0);
    check("t7_ferr", frame_err, 1'b0);
    sck = 1'b0; csn = 1'b1; mosi = 1'b0; wait_n(2);
    rst_n = 1'b1; wait_n(4);
    rx_ready = 1'b1; got.delete(); f0 = ferr_cnt;
    send_frame(9'h123, 0);
    check("t7_n", got.size(), 1);
    check("t7_rx", got[0], 9'h123);
    check("t7_miso_rst", mo_word, 9'h000);
    check("t7_noferr", ferr_cnt - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_lcd_slave.md
Name: spi_lcd_slave

Overview:
- SPI target-side model/responder for the 9-bit LCD link driven by the SPI master peripheral. Frame bit 8 is the D/C flag.
- Oversamples csn/sck/mosi in the bus clock domain and deserialises mode-0 frames, MSB first, into a FIFO of words with a valid/ready read side.
- Serialises a preloaded response word on miso.
- Used as the LCD end in system simulation and as a loopback target on the FPGA.

Parameters:
- FRAME_BITS, 9: bits per frame. Bit FRAME_BITS-1 is D/C.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of 2, ≥2.
- SYNC_STAGES, 2: flip-flop synchroniser depth on csn, sck and mosi.

Ports:
- Bus2IP_Clk  in  1  system clock. sck must be ≤ Bus2IP_Clk/8.
- Bus2IP_Resetn  in  1  asynchronous active-low reset.
- csn  in  1  chip select, active low.
- sck  in  1  SPI clock, idle low (mode 0).
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  high while selected.
- tx_data  in  FRAME_BITS  response word.
- tx_we  in  1  latch tx_data into the response holding register.
- rx_data  out  FRAME_BITS  head-of-FIFO word.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop head when rx_valid is also high.
- rx_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped.
- overflow_clr  in  1  clears overflow.
- frame_err  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Reset values (asynchronous): all outputs 0; FIFO empty; bit counter 0; response holding register 0; synchronisers reset to idle (csn=1, sck=0, mosi=0).
- Edge detection: the registered synchronised sck is compared with its previous value.
  - rise = 0→1, fall = 1→0, each a single-cycle strobe.
  - csn_fall and csn_rise are formed the same way.
- Selected = synchronised csn is low. sck edges while deselected are ignored.
- Receive path:
  - On each rise while selected, shift the synchronised mosi into rx_shift LSB-side (MSB arrives first) and increment bit_cnt.
  - When bit_cnt reaches FRAME_BITS-1 at a rise, push the completed word into the FIFO in that cycle and reset bit_cnt to 0.
  - rx_valid goes high the next cycle.
  - Pin-to-rx_valid latency: SYNC_STAGES+2 clocks after the final sck rising edge.
- Back-to-back frames within one csn-low period are legal. The counter wraps and the next frame starts immediately.
- Abort: on csn_rise with bit_cnt≠0, discard the partial word, clear bit_cnt, and pulse frame_err for 1 cycle. csn_rise with bit_cnt=0 is silent.
- FIFO:
  - First-word-fall-through: rx_data = head whenever rx_valid.
  - Pop when rx_valid & rx_ready.
  - Push when full and no pop: drop the new word, set overflow, FIFO contents unchanged.
  - Push when full with a simultaneous pop: both happen, count unchanged, no overflow.
  - Push when empty with rx_ready high: the word is stored, not bypassed.
  - Pointers wrap modulo FIFO_DEPTH.
  - If overflow_clr coincides with an overflow event, set wins.
- Transmit path:
  - tx_we loads the holding register; the last write wins, and the value persists across frames.
  - On csn_fall, and on each word boundary within a selected period, load tx_shift from the holding register and drive its MSB on miso.
  - On each fall while selected, shift left and drive the next bit.
  - Master requirement: ≥4 clocks from csn fall to the first sck rise.
  - miso_oe = selected. miso = 0 when deselected.
  - tx_we during a frame affects only the next frame.
- csn rising mid-frame also stops miso shifting (miso_oe=0).
- Reset mid-frame: everything returns to reset values immediately. The following csn-low period starts a clean frame.

Test Plan:
- Send frames 0x1FF then 0x15A (sck = clk/8), rx_ready=1 → rx_data outputs 0x1FF then 0x15A, each with rx_valid for one cycle; frame_err=0, overflow=0.
- tx_we with tx_data=0x0A5 before the frame; master sends 0x100 → sampled miso bits 0,1,0,1,0,0,1,0,1 (MSB first); rx_data=0x100.
- Five frames 0x001..0x005 with rx_ready=0 → rx_count=4, overflow=1. Pop four → 0x001..0x004. overflow_clr → overflow=0.
- csn rises after 4 bits of a frame → frame_err pulses once, FIFO unchanged. Next full frame 0x0C3 → received correctly.
- Single csn-low period carrying 18 bits (0x1FF, 0x02A) → two FIFO entries, in order.
- Full FIFO with push and pop in the same cycle → count stays 4, no overflow, new word appears at the tail.
- Assert Bus2IP_Resetn=0 mid-frame → all outputs 0. A subsequent frame 0x123 is received intact.
